// File: rtl/adc_max10_arbiter.sv
// adc_max10_arbiter: round-robin sharing of one MAX10 ADC sequencer among several requesters,
// with an in-order tag FIFO that routes each response back to its owner.
module adc_max10_arbiter #(
   parameter int REQ_COUNT   = 4,
   parameter int OUTSTANDING = 4
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [REQ_COUNT-1:0]   req_valid,
   input  logic [REQ_COUNT*5-1:0] req_channel,
   output logic [REQ_COUNT-1:0]   req_ready,
   output logic [REQ_COUNT-1:0]   rsp_valid,
   output logic [4:0]             rsp_channel,
   output logic [11:0]            rsp_data,
   output logic                   ADC_C_Valid,
   output logic [4:0]             ADC_C_Channel,
   output logic                   ADC_C_SOP,
   output logic                   ADC_C_EOP,
   input  logic                   ADC_C_Ready,
   input  logic                   ADC_R_Valid,
   input  logic [4:0]             ADC_R_Channel,
   input  logic [11:0]            ADC_R_Data,
   input  logic                   ADC_R_SOP,
   input  logic                   ADC_R_EOP,
   output logic                   busy,
   output logic                   err_mismatch,
   output logic                   err_unexpected,
   input  logic                   clr_err
);
   localparam int IDW = $clog2(REQ_COUNT);
   localparam int AW  = $clog2(OUTSTANDING);
   localparam logic [AW:0] FULL = (AW+1)'(OUTSTANDING);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t          r_state, w_state_nxt;
   logic [IDW-1:0]  r_rr_ptr, w_win;
   logic            w_any, w_grant, w_pop, w_full, w_empty;
   logic [4:0]      r_cmd_ch, w_win_ch, w_head_ch;
   logic [IDW-1:0]  w_head_id;
   logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [AW:0]     r_count;
   logic [IDW-1:0]  r_fifo_id [OUTSTANDING];
   logic [4:0]      r_fifo_ch [OUTSTANDING];
   logic [REQ_COUNT-1:0] r_rsp_valid;
   logic [4:0]      r_rsp_ch;
   logic [11:0]     r_rsp_data;
   logic            r_err_mm, r_err_ue;
   logic            w_unused;

   assign w_unused = ADC_R_SOP ^ ADC_R_EOP;

   // scan offsets from high to low so the lowest offset from rr_ptr wins
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int k = REQ_COUNT - 1; k >= 0; k--) begin
         if (req_valid[(int'(r_rr_ptr) + k) % REQ_COUNT]) begin
            w_any = 1'b1;
            w_win = IDW'((int'(r_rr_ptr) + k) % REQ_COUNT);
         end
      end
   end

   assign w_full      = r_count == FULL;
   assign w_empty     = r_count == '0;
   assign w_win_ch    = req_channel[int'(w_win)*5 +: 5];
   assign w_head_id   = r_fifo_id[r_rd_ptr];
   assign w_head_ch   = r_fifo_ch[r_rd_ptr];
   assign w_pop       = ADC_R_Valid && !w_empty;

   always_comb begin
      w_grant     = (r_state == IDLE) && w_any && !w_full && !RESET;
      w_state_nxt = w_grant ? ISSUE : ((r_state == ISSUE) && ADC_C_Ready) ? IDLE : r_state;
      req_ready   = w_grant ? (REQ_COUNT'(1) << w_win) : '0;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_cmd_ch    <= '0;
         r_rsp_valid <= '0;
         r_rsp_ch    <= '0;
         r_rsp_data  <= '0;
         r_err_mm    <= 1'b0;
         r_err_ue    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_cmd_ch            <= w_win_ch;
            r_fifo_id[r_wr_ptr] <= w_win;
            r_fifo_ch[r_wr_ptr] <= w_win_ch;
            r_wr_ptr            <= r_wr_ptr + 1'b1;
            r_rr_ptr            <= (w_win == IDW'(REQ_COUNT - 1)) ? '0 : w_win + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_rsp_ch   <= ADC_R_Channel;
            r_rsp_data <= ADC_R_Data;
         end
         r_count     <= r_count + (AW+1)'(w_grant) - (AW+1)'(w_pop);
         r_rsp_valid <= w_pop ? (REQ_COUNT'(1) << w_head_id) : '0;
         // a new error event takes priority over a simultaneous clear
         r_err_mm    <= (w_pop && (ADC_R_Channel != w_head_ch)) || (r_err_mm && !clr_err);
         r_err_ue    <= (ADC_R_Valid && w_empty) || (r_err_ue && !clr_err);
      end
   end

   assign ADC_C_Valid    = r_state == ISSUE;
   assign ADC_C_SOP      = r_state == ISSUE;
   assign ADC_C_EOP      = r_state == ISSUE;
   assign ADC_C_Channel  = r_cmd_ch;
   assign rsp_valid      = r_rsp_valid;
   assign rsp_channel    = r_rsp_ch;
   assign rsp_data       = r_rsp_data;
   assign busy           = (r_state == ISSUE) || !w_empty;
   assign err_mismatch   = r_err_mm;
   assign err_unexpected = r_err_ue;
endmodule

// File: tb/tb_adc_max10_arbiter.sv
// tb_adc_max10_arbiter: directed checks of grant order, ADC handshake, response routing,
// FIFO-full stall, error flags and mid-operation reset.
module tb_adc_max10_arbiter;
   logic        CLK, RESET;
   logic [3:0]  req_valid, req_ready, rsp_valid;
   logic [19:0] req_channel;
   logic [4:0]  rsp_channel, ADC_C_Channel, ADC_R_Channel;
   logic [11:0] rsp_data, ADC_R_Data;
   logic        ADC_C_Valid, ADC_C_SOP, ADC_C_EOP, ADC_C_Ready;
   logic        ADC_R_Valid, ADC_R_SOP, ADC_R_EOP;
   logic        busy, err_mismatch, err_unexpected, clr_err;
   int          n_chk = 0, n_fail = 0;

   adc_max10_arbiter #(.REQ_COUNT(4), .OUTSTANDING(4)) dut (
      .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_channel(req_channel),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel),
      .rsp_data(rsp_data), .ADC_C_Valid(ADC_C_Valid), .ADC_C_Channel(ADC_C_Channel),
      .ADC_C_SOP(ADC_C_SOP), .ADC_C_EOP(ADC_C_EOP), .ADC_C_Ready(ADC_C_Ready),
      .ADC_R_Valid(ADC_R_Valid), .ADC_R_Channel(ADC_R_Channel), .ADC_R_Data(ADC_R_Data),
      .ADC_R_SOP(ADC_R_SOP), .ADC_R_EOP(ADC_R_EOP), .busy(busy),
      .err_mismatch(err_mismatch), .err_unexpected(err_unexpected), .clr_err(clr_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic respond(input logic [4:0] ch, input logic [11:0] data);
      ADC_R_Valid = 1'b1; ADC_R_Channel = ch; ADC_R_Data = data;
      step;
      ADC_R_Valid = 1'b0;
   endtask

   initial begin
      logic [4:0] drain_ch [3];
      logic [3:0] drain_own [3];
      drain_ch = '{5'd4, 5'd1, 5'd2};
      drain_own = '{4'b1000, 4'b0001, 4'b0010};
      RESET = 1'b1; req_valid = '0; req_channel = '0; ADC_C_Ready = 1'b1;
      ADC_R_Valid = 1'b0; ADC_R_Channel = '0; ADC_R_Data = '0;
      ADC_R_SOP = 1'b0; ADC_R_EOP = 1'b0; clr_err = 1'b0;
      step; step;
      RESET = 1'b0;
      check("rst_ready", req_ready, 0);
      check("rst_cvalid", ADC_C_Valid, 0);
      check("rst_rspv", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_errs", {err_mismatch, err_unexpected}, 0);

      // single request from requester 2 on channel 5
      req_channel[14:10] = 5'd5; req_valid = 4'b0100;
      #1 check("single_ready", req_ready, 4'b0100);
      step; req_valid = '0;
      #1 check("single_cvalid", {ADC_C_Valid, ADC_C_SOP, ADC_C_EOP}, 3'b111);
      check("single_cch", ADC_C_Channel, 5);
      check("single_ready_issue", req_ready, 0);
      step;
      check("single_idle", ADC_C_Valid, 0);
      check("single_busy_out", busy, 1);
      respond(5'd5, 12'hABC);
      check("single_rspv", rsp_valid, 4'b0100);
      check("single_rspd", rsp_data, 12'hABC);
      check("single_rspc", rsp_channel, 5);
      check("single_busy_done", busy, 0);
      step;
      check("single_pulse", rsp_valid, 0);
      check("single_hold", rsp_data, 12'hABC);

      // fairness from rr_ptr = 0
      RESET = 1'b1; step; RESET = 1'b0;
      req_channel = {5'd4, 5'd3, 5'd2, 5'd1}; req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1 check("fair_grant", req_ready, 4'b0001 << (k % 4));
         step;
         check("fair_cch", ADC_C_Channel, (k % 4) + 1);
         respond(5'((k % 4) + 1), 12'(k));
         check("fair_rspv", rsp_valid, 4'b0001 << (k % 4));
      end
      req_valid = '0;

      // backpressure: rr_ptr = 1, only requester 0 asks, so the pointer wraps
      ADC_C_Ready = 1'b0; req_valid = 4'b0001;
      #1 check("bp_grant", req_ready, 4'b0001);
      step;
      for (int k = 0; k < 10; k++) begin
         #1 check("bp_cvalid", ADC_C_Valid, 1);
         check("bp_cch", ADC_C_Channel, 1);
         check("bp_ready", req_ready, 0);
         step;
      end
      ADC_C_Ready = 1'b1; req_valid = '0;
      #1 check("bp_still", ADC_C_Valid, 1);
      step;
      check("bp_release", ADC_C_Valid, 0);
      respond(5'd1, 12'h111);
      check("bp_rspv", rsp_valid, 4'b0001);
      check("bp_busy", busy, 0);

      // FIFO full
      RESET = 1'b1; step; RESET = 1'b0;
      req_valid = 4'b1111;
      repeat (8) step;
      #1 check("full_ready", req_ready, 0);
      check("full_busy", busy, 1);
      repeat (5) step;
      check("full_ready_hold", req_ready, 0);
      check("full_cvalid", ADC_C_Valid, 0);
      respond(5'd1, 12'h001);
      check("full_rspv0", rsp_valid, 4'b0001);
      #1 check("full_regrant", req_ready, 4'b0001);
      respond(5'd2, 12'h002);
      check("full_rspv1", rsp_valid, 4'b0010);
      check("full_cch", ADC_C_Channel, 1);
      step;
      #1 check("full_pushpop_slot", req_ready, 4'b0010);
      step; step;
      #1 check("full_again", req_ready, 0);
      req_valid = '0;

      // errors: head is requester 2 expecting channel 3
      respond(5'd7, 12'h123);
      check("err_mm", err_mismatch, 1);
      check("err_mm_rspv", rsp_valid, 4'b0100);
      check("err_mm_rspc", rsp_channel, 7);
      for (int k = 0; k < 3; k++) begin
         respond(drain_ch[k], 12'(12'h200 + k));
         check("err_drain_rspv", rsp_valid, drain_own[k]);
      end
      check("err_ue_clear", err_unexpected, 0);
      check("err_drain_busy", busy, 0);
      respond(5'd9, 12'hFFF);
      check("err_ue", err_unexpected, 1);
      check("err_ue_rspv", rsp_valid, 0);
      check("err_ue_hold", rsp_data, 12'h202);
      check("err_mm_sticky", err_mismatch, 1);
      clr_err = 1'b1; step; clr_err = 1'b0;
      check("err_clr", {err_mismatch, err_unexpected}, 0);
      clr_err = 1'b1; respond(5'd9, 12'h0); clr_err = 1'b0;
      check("err_set_wins", err_unexpected, 1);

      // mid-operation reset with two commands outstanding
      clr_err = 1'b1; step; clr_err = 1'b0;
      req_valid = 4'b0011;
      repeat (4) step;
      req_valid = '0;
      #1 check("mid_busy", busy, 1);
      RESET = 1'b1; step; RESET = 1'b0;
      check("mid_busy_rst", busy, 0);
      check("mid_outs", {ADC_C_Valid, ADC_C_Channel, rsp_valid, rsp_data}, 0);
      check("mid_errs", {err_mismatch, err_unexpected}, 0);
      respond(5'd1, 12'h055);
      check("mid_late0_ue", err_unexpected, 1);
      check("mid_late0_rspv", rsp_valid, 0);
      clr_err = 1'b1; step; clr_err = 1'b0;
      check("mid_clr", err_unexpected, 0);
      respond(5'd2, 12'h066);
      check("mid_late1_ue", err_unexpected, 1);
      check("mid_late1_rspv", rsp_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/adc_max10_arbiter.md
Name: adc_max10_arbiter

Overview:
- Shares the single MAX10 ADC sequencer between REQ_COUNT independent requesters, for example the core scan engine, a temperature monitor and a debug port.
- Requesters submit single-channel conversion requests; the arbiter grants them round-robin and drives the Avalon-ST command interface.
- Each response is routed back to the requester that issued it, using an in-order tag FIFO of outstanding commands.
- Sits between the requester blocks and adc_core's command/response ports.

Parameters:
- REQ_COUNT, 4, number of requesters (2..8).
- OUTSTANDING, 4, tag FIFO depth = maximum commands in flight (power of 2).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  REQ_COUNT  per-requester conversion request.
- req_channel  in  REQ_COUNT*5  channel per requester; requester i uses bits [5i+4:5i].
- req_ready  out  REQ_COUNT  grant; transfer when req_valid[i] & req_ready[i].
- rsp_valid  out  REQ_COUNT  one-cycle pulse to the owning requester.
- rsp_channel  out  5  returned channel, shared by all requesters.
- rsp_data  out  12  returned sample, shared by all requesters.
- ADC_C_Valid  out  1  command valid.
- ADC_C_Channel  out  5  command channel.
- ADC_C_SOP  out  1  command start of packet.
- ADC_C_EOP  out  1  command end of packet.
- ADC_C_Ready  in  1  command accepted by the ADC.
- ADC_R_Valid  in  1  response valid.
- ADC_R_Channel  in  5  response channel.
- ADC_R_Data  in  12  response sample.
- ADC_R_SOP  in  1  ignored.
- ADC_R_EOP  in  1  ignored.
- busy  out  1  high when state=ISSUE or the tag FIFO is non-empty.
- err_mismatch  out  1  sticky flag: response channel differs from the expected channel.
- err_unexpected  out  1  sticky flag: response arrived with nothing outstanding.
- clr_err  in  1  clears both sticky error flags.

Behaviour:
- Reset (synchronous, RESET=1 at a CLK edge):
  - state=IDLE, rr_ptr=0, tag FIFO emptied.
  - All outputs 0, including both error flags.
  - Reset mid-operation discards every outstanding tag and any pending command.
- State machine, IDLE -> ISSUE -> IDLE.
- IDLE:
  - If any req_valid bit is set and the FIFO is not full, the winner is the first asserted index at or above rr_ptr, wrapping modulo REQ_COUNT.
  - req_ready[winner]=1 combinationally in that cycle only; all other req_ready bits are 0.
  - On that edge: latch the winner's channel into the command register, push {winner, channel} into the FIFO, set rr_ptr=(winner+1) mod REQ_COUNT, and go to ISSUE.
  - If the FIFO is full, all req_ready bits are 0 and the arbiter stays in IDLE.
- ISSUE:
  - ADC_C_Valid=1, ADC_C_SOP=1, ADC_C_EOP=1; ADC_C_Channel holds the latched channel.
  - All outputs stay stable until ADC_C_Ready=1; on that edge return to IDLE.
  - req_ready stays all-0 throughout ISSUE.
  - Peak throughput is one command per 2 cycles.
- Response path (processed in any state):
  - On ADC_R_Valid with the FIFO non-empty: pop the head entry.
  - Next cycle: rsp_valid[head.id]=1 for exactly one cycle, with rsp_data=ADC_R_Data and rsp_channel=ADC_R_Channel, registered.
  - If ADC_R_Channel != head.channel, set err_mismatch; the response is still delivered to head.id.
  - On ADC_R_Valid with the FIFO empty: drop the response, set err_unexpected, pulse no rsp_valid. This is also the required behaviour for in-flight responses after a mid-operation reset.
- FIFO push and pop in the same cycle are legal; the count is unchanged.
  - A push when full cannot occur, because no grant is issued when full.
  - A pop when empty is handled as err_unexpected.
- Error flags: clr_err clears both flags on the next edge. If clr_err coincides with a new error event, the set wins.
- Channel values pass through unchecked; legality is the requester's responsibility.
- rsp_data and rsp_channel hold their last value between responses.

Test Plan:
- Single request, ADC_C_Ready held high: reset, then req_valid[2]=1 with channel 5.
  - req_ready[2] high for 1 cycle, next cycle ADC_C_Valid=1 with channel 5 and SOP=EOP=1.
  - Drive ADC_R_Valid with channel 5, data 0xABC -> rsp_valid[2] pulses 1 cycle later with rsp_data=0xABC.
- Fairness: all four req_valid held high with channels 1,2,3,4 and ADC_C_Ready=1.
  - Grant order is 0,1,2,3,0.
  - ADC_C_Channel sequence is 1,2,3,4,1.
  - rr_ptr wraps to 0.
- Backpressure: ADC_C_Ready=0 for 10 cycles during ISSUE.
  - ADC_C_Valid and ADC_C_Channel stay stable; all req_ready bits are 0.
  - After Ready goes high, return to IDLE on the next edge.
- FIFO full: OUTSTANDING=4, 4 commands issued, no responses returned.
  - 5th request sees req_ready=0 indefinitely.
  - One response frees a slot -> grant follows on the next IDLE cycle.
  - Drive a response on the same cycle as a grant -> FIFO count stays 4.
- Errors: respond with channel 7 while the head expects 3 -> err_mismatch=1 and rsp_valid goes to the head owner.
  - A response with the FIFO empty -> err_unexpected=1 and no rsp_valid.
  - clr_err -> both flags 0.
- Mid-operation reset: assert RESET with 2 commands outstanding.
  - All outputs return to 0 and busy=0.
  - Each of the 2 late responses sets err_unexpected and pulses no rsp_valid.
